// File: rtl/rv_emu_retire_checker.sv
// rv_emu_retire_checker
// Buffers expected-result records from the RV emulator and compares each one,
// in order, against the CPU retire stream. Only fields whose CHECKS flag is
// set in the record are compared. Results are a sticky error flag, saturating
// counters and a per-field mismatch mask. Has no effect on architectural state.
//
// Optional feature: define RV_EMU_CHK_FIRST_ERR_EN to build a register that
// captures exp_pc of the first mismatching compare (underflow excluded).
// Without it, first_err_pc is tied to 0.
//
// CHECKS layout (bit : field)
//   14 pc | 13 rs1_rd | 12 rs1_addr | 11 rs2_rd | 10 rs2_addr | 9 gpr_wr
//    8 gpr_addr | 7 gpr_data | 6 csr_rd | 5 csr_rd_data | 4 csr_wr
//    3 csr_wr_data | 2 exceptions | 1 events | 0 mode
//
// state  | meaning
// S_IDLE | not comparing; retires ignored, FIFO keeps filling
// S_RUN  | each retire is compared against the FIFO head
// S_HALT | stopped after an error; only reset leaves this state
module rv_emu_retire_checker #(
    parameter int DEPTH       = 8,
    parameter int CNT_W       = 16,
    parameter int HALT_ON_ERR = 1
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             chk_en,
    input  logic             exp_valid,
    output logic             exp_ready,
    input  logic [14:0]      exp_checks,
    input  logic [31:0]      exp_pc,
    input  logic [31:0]      exp_gpr_data,
    input  logic [31:0]      exp_csr_wr_data,
    input  logic             exp_gpr_wr,
    input  logic             exp_csr_wr,
    input  logic [4:0]       exp_gpr_addr,
    input  logic [1:0]       exp_mode,
    input  logic             ret_valid,
    input  logic [31:0]      ret_pc,
    input  logic [31:0]      ret_gpr_data,
    input  logic [31:0]      ret_csr_wr_data,
    input  logic             ret_gpr_wr,
    input  logic             ret_csr_wr,
    input  logic [4:0]       ret_gpr_addr,
    input  logic [1:0]       ret_mode,
    output logic             err,
    output logic [14:0]      err_mask,
    output logic             underflow,
    output logic [CNT_W-1:0] cmp_cnt,
    output logic [CNT_W-1:0] mis_cnt,
    output logic [31:0]      first_err_pc
);

    localparam int AW = $clog2(DEPTH);

    // Only the CHECKS bits that are actually compared are stored.
    typedef struct packed {
        logic [6:0]  chk;    // {pc, gpr_wr, gpr_addr, gpr_data, csr_wr, csr_wr_data, mode}
        logic [31:0] pc;
        logic        gpr_wr;
        logic [4:0]  gpr_addr;
        logic [31:0] gpr_data;
        logic        csr_wr;
        logic [31:0] csr_wr_data;
        logic [1:0]  mode;
    } rec_t;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    rec_t             r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    state_t           r_state;
    logic             r_err;
    logic [14:0]      r_err_mask;
    logic             r_underflow;
    logic [CNT_W-1:0] r_cmp_cnt;
    logic [CNT_W-1:0] r_mis_cnt;

    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_ret;
    logic             w_pop;
    logic             w_unf;
    logic             w_mis;
    rec_t             w_wr_rec;
    rec_t             w_head;
    logic [14:0]      w_mask;
    logic             w_unused_chk;

    // Unchecked CHECKS bits are accepted on the port but never stored.
    assign w_unused_chk = ^{exp_checks[13:10], exp_checks[6:5], exp_checks[2:1]};

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign exp_ready = !w_full;
    assign w_push    = exp_valid && !w_full;
    assign w_ret     = ret_valid && (r_state == S_RUN);
    assign w_pop     = w_ret && !w_empty;
    assign w_unf     = w_ret && w_empty;

    assign w_wr_rec = '{chk:         {exp_checks[14], exp_checks[9], exp_checks[8],
                                      exp_checks[7], exp_checks[4], exp_checks[3],
                                      exp_checks[0]},
                        pc:          exp_pc,
                        gpr_wr:      exp_gpr_wr,
                        gpr_addr:    exp_gpr_addr,
                        gpr_data:    exp_gpr_data,
                        csr_wr:      exp_csr_wr,
                        csr_wr_data: exp_csr_wr_data,
                        mode:        exp_mode};

    assign w_head = r_mem[r_rd_ptr[AW-1:0]];

    // Per-field mismatch of the FIFO head against the retire record; data and
    // address fields only matter when the emulator says a write happened.
    always_comb begin
        w_mask     = '0;
        w_mask[14] = w_head.chk[6] && (w_head.pc != ret_pc);
        w_mask[9]  = w_head.chk[5] && (w_head.gpr_wr != ret_gpr_wr);
        w_mask[8]  = w_head.chk[4] && w_head.gpr_wr && (w_head.gpr_addr != ret_gpr_addr);
        w_mask[7]  = w_head.chk[3] && w_head.gpr_wr && (w_head.gpr_data != ret_gpr_data);
        w_mask[4]  = w_head.chk[2] && (w_head.csr_wr != ret_csr_wr);
        w_mask[3]  = w_head.chk[1] && w_head.csr_wr && (w_head.csr_wr_data != ret_csr_wr_data);
        w_mask[0]  = w_head.chk[0] && (w_head.mode != ret_mode);
    end

    assign w_mis = w_pop && (w_mask != 15'd0);

    // FIFO storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_wr_rec;
        end
    end

    // Pointers, state machine, counters and sticky result flags.
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_state     <= S_IDLE;
            r_err       <= 1'b0;
            r_err_mask  <= '0;
            r_underflow <= 1'b0;
            r_cmp_cnt   <= '0;
            r_mis_cnt   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (chk_en) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if ((w_mis || w_unf) && (HALT_ON_ERR != 0)) begin
                        r_state <= S_HALT;
                    end else if (!chk_en) begin
                        r_state <= S_IDLE;
                    end
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_IDLE;
            endcase

            if (w_pop && (r_cmp_cnt != '1)) begin
                r_cmp_cnt <= r_cmp_cnt + CNT_W'(1);
            end
            if ((w_mis || w_unf) && (r_mis_cnt != '1)) begin
                r_mis_cnt <= r_mis_cnt + CNT_W'(1);
            end
            if (w_mis || w_unf) begin
                r_err <= 1'b1;
            end
            if (w_mis) begin
                r_err_mask <= w_mask;
            end
            if (w_unf) begin
                r_underflow <= 1'b1;
            end
        end
    end

`ifdef RV_EMU_CHK_FIRST_ERR_EN
    logic        r_first_vld;
    logic [31:0] r_first_err_pc;

    // Latch the expected pc of the first real mismatch and hold it.
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            r_first_vld    <= 1'b0;
            r_first_err_pc <= '0;
        end else if (w_mis && !r_first_vld) begin
            r_first_vld    <= 1'b1;
            r_first_err_pc <= w_head.pc;
        end
    end

    assign first_err_pc = r_first_err_pc;
`else
    assign first_err_pc = 32'd0;
`endif

    assign err       = r_err;
    assign err_mask  = r_err_mask;
    assign underflow = r_underflow;
    assign cmp_cnt   = r_cmp_cnt;
    assign mis_cnt   = r_mis_cnt;

endmodule
